file_op_unit: RTL and testbench
===============================

FILE_OP_UNIT -- requirements
Module: file_op_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data path width; all data/status ports use it.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port opValid  in  1  byte-oriented instruction offered.
REQ-005 SHALL have port opReady  out  1  high only in IDLE; transfer when opValid&&opReady at a rising edge.
REQ-006 SHALL have port instr  in  10  {opcode[9:6], d[5], f[4:0]}.
REQ-007 SHALL have port regfileIn  in  DATA_WIDTH  read data for file address on fileAddr.
REQ-008 SHALL have port statusIn  in  DATA_WIDTH  current STATUS register.
REQ-009 SHALL have port writeCommand  out  3  000 none, 001 status only, 010 file data, 011 file data + status.
REQ-010 SHALL have port fileAddr  out  5  file address for read and write.
REQ-011 SHALL have port writeDataOut  out  DATA_WIDTH  file write data.
REQ-012 SHALL have port statusOut  out  DATA_WIDTH  new STATUS value.
REQ-013 SHALL have port wOut  out  DATA_WIDTH  W working register.
REQ-014 SHALL have ports done and skip  out  1 each  completion pulse; skip-next flag valid with done.

Function
REQ-015 SHALL implement FSM IDLE->READ->EXEC->WRITE->IDLE, one cycle per non-IDLE state; leave IDLE only on accepted transfer.
REQ-016 SHALL latch instr on accept and hold fileAddr = latched f from READ through WRITE; fileAddr = 0 in IDLE.
REQ-017 SHALL sample regfileIn and statusIn at the end of READ; EXEC registers result and flags.
REQ-018 SHALL, in WRITE only, drive writeCommand nonzero for exactly one cycle, update W if d=0, and pulse done=1; done asserted 3 cycles after accept edge.
REQ-019 SHALL decode opcode/d: 0000 d0 NOP, d1 MOVWF; 0001 d0 CLRW, d1 CLRF; 0010 SUBWF; 0011 DECF; 0100 IORWF; 0101 ANDWF; 0110 XORWF; 0111 ADDWF; 1000 MOVF; 1001 COMF; 1010 INCF; 1011 DECFSZ; 1100 RRF; 1101 RLF; 1110 SWAPF; 1111 INCFSZ.
REQ-020 SHALL compute modulo 2^DATA_WIDTH; SUBWF = f - W; RRF/RLF rotate through C (status bit 0).
REQ-021 SHALL update flags: Z=bit2, DC=bit1, C=bit0; ADDWF/SUBWF set C,DC,Z (SUBWF C,DC = no-borrow); logic ops, MOVF, COMF, INCF, DECF, CLRF, CLRW set Z; RRF/RLF set C; others none; statusOut bits 7:3 = sampled statusIn.
REQ-022 SHALL select writeCommand: result to file (d=1, MOVWF, CLRF) with flag change 011, without 010; result to W (d=0, CLRW) with flag change 001, without 000; NOP 000.
REQ-023 SHALL write MOVWF data = W, CLRF/CLRW result = 0 with Z=1.
REQ-024 SHALL set skip=1 with done for DECFSZ/INCFSZ when result = 0, else 0.
REQ-025 SHALL ignore opValid outside IDLE; with opValid held, accept one instruction every 4 cycles.
REQ-026 SHALL not arbitrate STATUS-as-target; when f = STATUS with 011, register-file precedence applies.

Reset
REQ-027 SHALL on rst low immediately enter IDLE: W=0, writeCommand=000, fileAddr=0, writeDataOut=0, statusOut=0, done=0, skip=0, opReady=1.
REQ-028 SHALL abort any in-flight op on reset with no write issued and W unchanged from its reset value.

Verification
REQ-029 ADDWF d=1, W=0x0F, f=0x08 reads 0xF1 -> WRITE: writeCommand=011, fileAddr=0x08, writeDataOut=0x00, statusOut[2:0]=111.
REQ-030 SUBWF d=0, W=0x05, f reads 0x03 -> writeCommand=001, wOut=0xFE, statusOut[2:0]=000.
REQ-031 DECFSZ d=1, f reads 0x01 -> writeCommand=010, writeDataOut=0x00, done=1, skip=1; f reads 0x02 -> 0x01, skip=0.
REQ-032 RRF d=1, statusIn[0]=1, f reads 0x02 -> writeCommand=011, writeDataOut=0x81, statusOut[0]=0.
REQ-033 rst low during EXEC -> writeCommand stays 000, done never pulses, wOut=0, opReady=1 next cycle.
REQ-034 opValid held high, 3 back-to-back INCF -> accepts at cycles 0,4,8; done at 3,7,11; no lost/duplicate writes.

Source files
------------

// File: rtl/file_op_unit.sv
// Byte-oriented file-register instruction unit: fetches one operand from the register
// file, executes an ALU op against W, then issues a single write/status command.
module file_op_unit #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  opValid,
  output logic                  opReady,
  input  logic [9:0]            instr,
  input  logic [DATA_WIDTH-1:0] regfileIn,
  input  logic [DATA_WIDTH-1:0] statusIn,
  output logic [2:0]            writeCommand,
  output logic [4:0]            fileAddr,
  output logic [DATA_WIDTH-1:0] writeDataOut,
  output logic [DATA_WIDTH-1:0] statusOut,
  output logic [DATA_WIDTH-1:0] wOut,
  output logic                  done,
  output logic                  skip
);

  localparam int HALF = DATA_WIDTH / 2;
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t                state_q;
  logic [3:0]            opcode_q;
  logic                  d_q;
  logic [4:0]            fileAddr_q;
  logic [DATA_WIDTH-1:0] fval_q, stat_q, w_q;
  logic [DATA_WIDTH-1:0] writeDataOut_q, statusOut_q;
  logic [2:0]            writeCommand_q;
  logic                  opReady_q, done_q, skip_q;

  logic [DATA_WIDTH-1:0] res_d, stat_d;
  logic [DATA_WIDTH:0]   sum;
  logic [2:0]            cmd_d;
  logic                  skip_d, to_w, z_upd, c_upd, c_new, dc_new;

  always_comb begin
    res_d  = fval_q;
    sum    = '0;
    c_new  = stat_q[0];
    dc_new = stat_q[1];
    z_upd  = 1'b0;
    c_upd  = 1'b0;
    skip_d = 1'b0;
    to_w   = ~d_q;
    case (opcode_q)
      4'h0: begin res_d = w_q; to_w = 1'b0; end
      4'h1: begin res_d = '0; z_upd = 1'b1; end
      4'h2: begin
        // Carry and digit carry are "no borrow" for subtraction
        res_d  = fval_q - w_q;
        c_new  = (fval_q >= w_q);
        dc_new = (fval_q[3:0] >= w_q[3:0]);
        z_upd  = 1'b1;
        c_upd  = 1'b1;
      end
      4'h3: begin res_d = fval_q - ONE; z_upd = 1'b1; end
      4'h4: begin res_d = fval_q | w_q; z_upd = 1'b1; end
      4'h5: begin res_d = fval_q & w_q; z_upd = 1'b1; end
      4'h6: begin res_d = fval_q ^ w_q; z_upd = 1'b1; end
      4'h7: begin
        sum    = {1'b0, fval_q} + {1'b0, w_q};
        res_d  = sum[DATA_WIDTH-1:0];
        c_new  = sum[DATA_WIDTH];
        dc_new = (({1'b0, fval_q[3:0]} + {1'b0, w_q[3:0]}) > 5'd15);
        z_upd  = 1'b1;
        c_upd  = 1'b1;
      end
      4'h8: begin res_d = fval_q; z_upd = 1'b1; end
      4'h9: begin res_d = ~fval_q; z_upd = 1'b1; end
      4'hA: begin res_d = fval_q + ONE; z_upd = 1'b1; end
      4'hB: begin res_d = fval_q - ONE; skip_d = (res_d == '0); end
      4'hC: begin
        res_d = {stat_q[0], fval_q[DATA_WIDTH-1:1]};
        c_new = fval_q[0];
        c_upd = 1'b1;
      end
      4'hD: begin
        res_d = {fval_q[DATA_WIDTH-2:0], stat_q[0]};
        c_new = fval_q[DATA_WIDTH-1];
        c_upd = 1'b1;
      end
      4'hE: res_d = {fval_q[HALF-1:0], fval_q[DATA_WIDTH-1:HALF]};
      4'hF: begin res_d = fval_q + ONE; skip_d = (res_d == '0); end
    endcase
    stat_d = stat_q;
    if (z_upd) stat_d[2] = (res_d == '0);
    if (c_upd) begin
      stat_d[1] = dc_new;
      stat_d[0] = c_new;
    end
    cmd_d = {1'b0, d_q, z_upd | c_upd};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      opcode_q       <= '0;
      d_q            <= 1'b0;
      fileAddr_q     <= '0;
      fval_q         <= '0;
      stat_q         <= '0;
      w_q            <= '0;
      writeDataOut_q <= '0;
      statusOut_q    <= '0;
      writeCommand_q <= '0;
      opReady_q      <= 1'b1;
      done_q         <= 1'b0;
      skip_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (opValid) begin
          opcode_q   <= instr[9:6];
          d_q        <= instr[5];
          fileAddr_q <= instr[4:0];
          opReady_q  <= 1'b0;
          state_q    <= READ;
        end
        READ: begin
          fval_q  <= regfileIn;
          stat_q  <= statusIn;
          state_q <= EXEC;
        end
        EXEC: begin
          // Results land in the output registers so they are all valid for the WRITE cycle
          writeCommand_q <= cmd_d;
          writeDataOut_q <= res_d;
          statusOut_q    <= stat_d;
          if (to_w) w_q <= res_d;
          done_q  <= 1'b1;
          skip_q  <= skip_d;
          state_q <= WRITE;
        end
        WRITE: begin
          writeCommand_q <= '0;
          done_q         <= 1'b0;
          skip_q         <= 1'b0;
          fileAddr_q     <= '0;
          opReady_q      <= 1'b1;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign opReady      = opReady_q;
  assign writeCommand = writeCommand_q;
  assign fileAddr     = fileAddr_q;
  assign writeDataOut = writeDataOut_q;
  assign statusOut    = statusOut_q;
  assign wOut         = w_q;
  assign done         = done_q;
  assign skip         = skip_q;

endmodule

// File: tb/tb_file_op_unit.sv
// Scoreboard bench for file_op_unit: expectations queued at issue, compared on each done pulse.
module tb_file_op_unit;

  typedef struct packed {
    logic [2:0] cmd;
    logic [4:0] addr;
    logic [7:0] data;
    logic [7:0] status;
    logic [7:0] w;
    logic       skip;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       opValid = 1'b0;
  logic [9:0] instr = '0;
  logic [7:0] regfileIn = '0, statusIn = '0;
  logic       opReady, done, skip;
  logic [2:0] writeCommand;
  logic [4:0] fileAddr;
  logic [7:0] writeDataOut, statusOut, wOut;

  int   n_cmp = 0, n_err = 0, cyc = 0;
  int   acc_q[$];
  int   acc_log[$];
  exp_t sbq[$];
  logic [7:0] m_w = '0;

  file_op_unit #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .opValid(opValid), .opReady(opReady), .instr(instr),
    .regfileIn(regfileIn), .statusIn(statusIn), .writeCommand(writeCommand),
    .fileAddr(fileAddr), .writeDataOut(writeDataOut), .statusOut(statusOut),
    .wOut(wOut), .done(done), .skip(skip)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] cmd, input logic [4:0] addr, input logic [7:0] data,
                              input logic [7:0] status, input logic [7:0] w, input logic sk);
    exp_t e;
    e.cmd = cmd; e.addr = addr; e.data = data; e.status = status; e.w = w; e.skip = sk;
    return e;
  endfunction

  // Reference behaviour computed with integer arithmetic
  function automatic exp_t model(input logic [3:0] op, input logic d, input logic [4:0] f,
                                 input logic [7:0] fv, input logic [7:0] st, input logic [7:0] w);
    exp_t e;
    int a, b, r;
    logic c, dc, zu, fl, tow, sk;
    a = int'(fv); b = int'(w); r = 0;
    c = st[0]; dc = st[1]; zu = 1'b0; fl = 1'b0; tow = ~d; sk = 1'b0;
    case (op)
      4'h0: begin r = b; tow = 1'b0; end
      4'h1: begin r = 0; zu = 1'b1; end
      4'h2: begin r = (a - b + 256) % 256; c = (a >= b); dc = ((a % 16) >= (b % 16)); zu = 1'b1; fl = 1'b1; end
      4'h3: begin r = (a + 255) % 256; zu = 1'b1; end
      4'h4: begin r = a | b; zu = 1'b1; end
      4'h5: begin r = a & b; zu = 1'b1; end
      4'h6: begin r = a ^ b; zu = 1'b1; end
      4'h7: begin r = (a + b) % 256; c = (a + b > 255); dc = ((a % 16) + (b % 16) > 15); zu = 1'b1; fl = 1'b1; end
      4'h8: begin r = a; zu = 1'b1; end
      4'h9: begin r = 255 - a; zu = 1'b1; end
      4'hA: begin r = (a + 1) % 256; zu = 1'b1; end
      4'hB: begin r = (a + 255) % 256; sk = (r == 0); end
      4'hC: begin r = (c ? 128 : 0) + a / 2; c = (a % 2 == 1); fl = 1'b1; end
      4'hD: begin r = (a * 2) % 256 + (c ? 1 : 0); c = (a >= 128); fl = 1'b1; end
      4'hE: r = (a % 16) * 16 + a / 16;
      4'hF: begin r = (a + 1) % 256; sk = (r == 0); end
    endcase
    fl = fl | zu;
    e.cmd    = {1'b0, d, fl};
    e.addr   = f;
    e.data   = r[7:0];
    e.status = {st[7:3], zu ? (r == 0) : st[2], dc, c};
    e.w      = tow ? r[7:0] : w;
    e.skip   = sk;
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst && opValid && opReady) begin
      acc_q.push_back(cyc);
      acc_log.push_back(cyc);
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (rst) begin
      check("cmd_only_with_done", 32'(writeCommand & {3{~done}}), 32'd0);
      if (opReady) check("idle_fileaddr", 32'(fileAddr), 32'd0);
      if (done) begin
        if (sbq.size() == 0) check("spurious_done", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sbq.pop_front();
          check("writeCommand", 32'(writeCommand), 32'(e.cmd));
          check("fileAddr", 32'(fileAddr), 32'(e.addr));
          if (e.cmd[1]) check("writeDataOut", 32'(writeDataOut), 32'(e.data));
          check("statusOut", 32'(statusOut), 32'(e.status));
          check("wOut", 32'(wOut), 32'(e.w));
          check("skip", 32'(skip), 32'(e.skip));
          if (acc_q.size() == 0) check("accept_record", 32'd0, 32'd1);
          else check("done_latency", 32'(cyc - acc_q.pop_front()), 32'd3);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic d, input logic [4:0] f,
                       input logic [7:0] fv, input logic [7:0] st, input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    while (!opReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(opReady), 32'd1);
    instr = {op, d, f}; regfileIn = fv; statusIn = st; opValid = 1'b1;
    sbq.push_back(e);
    m_w = e.w;
    @(negedge clk);
    opValid = 1'b0;
  endtask

  task automatic issue_model(input logic [3:0] op, input logic d, input logic [4:0] f,
                             input logic [7:0] fv, input logic [7:0] st);
    issue(op, d, f, fv, st, model(op, d, f, fv, st, m_w));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || !opReady) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sbq.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_opReady", 32'(opReady), 32'd1);
    check("rst_writeCommand", 32'(writeCommand), 32'd0);
    check("rst_fileAddr", 32'(fileAddr), 32'd0);
    check("rst_writeDataOut", 32'(writeDataOut), 32'd0);
    check("rst_statusOut", 32'(statusOut), 32'd0);
    check("rst_wOut", 32'(wOut), 32'd0);
    check("rst_done_skip", 32'({done, skip}), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    issue(4'h8, 1'b0, 5'd3, 8'h0F, 8'h00, mk(3'b001, 5'd3, 8'h0F, 8'h00, 8'h0F, 1'b0));
    issue(4'h7, 1'b1, 5'h08, 8'hF1, 8'h00, mk(3'b011, 5'h08, 8'h00, 8'h07, 8'h0F, 1'b0));
    issue(4'h8, 1'b0, 5'd1, 8'h05, 8'h00, mk(3'b001, 5'd1, 8'h05, 8'h00, 8'h05, 1'b0));
    issue(4'h2, 1'b0, 5'd1, 8'h03, 8'h00, mk(3'b001, 5'd1, 8'hFE, 8'h00, 8'hFE, 1'b0));
    issue(4'hB, 1'b1, 5'd2, 8'h01, 8'hA5, mk(3'b010, 5'd2, 8'h00, 8'hA5, 8'hFE, 1'b1));
    issue(4'hB, 1'b1, 5'd2, 8'h02, 8'h00, mk(3'b010, 5'd2, 8'h01, 8'h00, 8'hFE, 1'b0));
    issue(4'hC, 1'b1, 5'd4, 8'h02, 8'h01, mk(3'b011, 5'd4, 8'h81, 8'h00, 8'hFE, 1'b0));
    issue(4'h1, 1'b0, 5'd5, 8'h77, 8'hF0, mk(3'b001, 5'd5, 8'h00, 8'hF4, 8'h00, 1'b0));
    issue(4'h1, 1'b1, 5'd7, 8'h77, 8'h00, mk(3'b011, 5'd7, 8'h00, 8'h04, 8'h00, 1'b0));
    issue(4'h8, 1'b0, 5'd1, 8'h5A, 8'h00, mk(3'b001, 5'd1, 8'h5A, 8'h00, 8'h5A, 1'b0));
    issue(4'h0, 1'b1, 5'd9, 8'h11, 8'h07, mk(3'b010, 5'd9, 8'h5A, 8'h07, 8'h5A, 1'b0));
    issue(4'h0, 1'b0, 5'd9, 8'h11, 8'h07, mk(3'b000, 5'd9, 8'h00, 8'h07, 8'h5A, 1'b0));
    issue(4'hD, 1'b1, 5'd3, 8'h80, 8'h00, mk(3'b011, 5'd3, 8'h00, 8'h01, 8'h5A, 1'b0));
    issue(4'hE, 1'b1, 5'd3, 8'h3C, 8'h00, mk(3'b010, 5'd3, 8'hC3, 8'h00, 8'h5A, 1'b0));
    issue(4'hF, 1'b0, 5'd6, 8'hFF, 8'h00, mk(3'b000, 5'd6, 8'h00, 8'h00, 8'h00, 1'b1));
    for (int i = 0; i < 24; i++)
      issue_model(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    wait_drain();

    // opValid held: three INCF accepted every fourth cycle
    acc_log.delete();
    instr = {4'hA, 1'b1, 5'd6}; regfileIn = 8'h10; statusIn = 8'h00;
    for (int i = 0; i < 3; i++) sbq.push_back(mk(3'b011, 5'd6, 8'h11, 8'h00, m_w, 1'b0));
    opValid = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    opValid = 1'b0;
    wait_drain();
    check("b2b_accepts", 32'(acc_log.size()), 32'd3);
    if (acc_log.size() == 3) begin
      check("b2b_gap0", 32'(acc_log[1] - acc_log[0]), 32'd4);
      check("b2b_gap1", 32'(acc_log[2] - acc_log[1]), 32'd4);
    end

    // Abort in EXEC
    issue(4'h8, 1'b0, 5'd2, 8'h3C, 8'h00, mk(3'b001, 5'd2, 8'h3C, 8'h00, 8'h3C, 1'b0));
    wait_drain();
    instr = {4'hA, 1'b0, 5'd2}; regfileIn = 8'h07; statusIn = 8'h00; opValid = 1'b1;
    @(negedge clk);
    opValid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_opReady", 32'(opReady), 32'd1);
    check("abort_writeCommand", 32'(writeCommand), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_wOut", 32'(wOut), 32'd0);
    check("abort_fileAddr", 32'(fileAddr), 32'd0);
    acc_q.delete();
    m_w = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("post_abort_wOut", 32'(wOut), 32'd0);
    check("post_abort_opReady", 32'(opReady), 32'd1);

    issue(4'h7, 1'b0, 5'd1, 8'h00, 8'h00, mk(3'b001, 5'd1, 8'h00, 8'h04, 8'h00, 1'b0));
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
